amba3_apb_arbiter: RTL

AMBA3_APB_ARBITER -- requirements
Module: amba3_apb_arbiter

---
 rtl/pkg_amba3.sv | 23 ++
 rtl/amba3_apb_arb_pick.sv | 45 ++++
 rtl/amba3_apb_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pkg_amba3.sv
// -----------------------------------------------------------------------------
// pkg_amba3
// Shared types for the AMBA3 APB arbiter slice.
//   amba3_apb_arb_state_t : APB master FSM state (IDLE / SETUP / ACCESS)
//   APB_MAX_REQ           : largest supported requester count
//   arb_is_idle()         : true when the FSM may arbitrate
// -----------------------------------------------------------------------------
package pkg_amba3;

  localparam int APB_MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } amba3_apb_arb_state_t;

  // Arbitration, and therefore req_ready, is only ever live in IDLE.
  function automatic logic arb_is_idle(input amba3_apb_arb_state_t st);
    return st == IDLE;
  endfunction

endpackage : pkg_amba3

// File: rtl/amba3_apb_arb_pick.sv
// -----------------------------------------------------------------------------
// amba3_apb_arb_pick
// Combinational winner selection for the APB arbiter.
// Scans req_valid starting at index 'pointer' and wrapping modulo NUM_REQ;
// the first asserted request wins.
//   With AMBA3_APB_ARBITER_RR_EN the top drives pointer = last winner + 1
//   (round-robin); without it the top ties pointer to 0, which reduces the
//   scan to fixed priority with the lowest index winning.
// Ports:
//   req_valid [NUM_REQ] in  : pending requests
//   pointer   [PTR_W]   in  : scan start index (0..NUM_REQ-1)
//   grant     [NUM_REQ] out : one-hot winner, all zero when nothing pending
// -----------------------------------------------------------------------------
module amba3_apb_arb_pick #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant
);

  int               sum;
  logic [PTR_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit written (k = 0,
  // closest to the pointer) is the one that survives.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    sum   = 0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(pointer) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = PTR_W'(sum);
      if (req_valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule : amba3_apb_arb_pick

// File: rtl/amba3_apb_arbiter.sv
// -----------------------------------------------------------------------------
// amba3_apb_arbiter
// N-requester to single AMBA3 APB master bridge. One transfer in flight;
// arbitration happens only in IDLE, the winner is latched and driven through
// SETUP (psel) and ACCESS (psel+penable) until pready, then a one-cycle
// rsp_valid pulse is returned to the owning requester.
//
// Configuration macro:
//   AMBA3_APB_ARBITER_RR_EN  defined   -> round-robin, pointer = last winner
//                            undefined -> fixed priority, lowest index wins
//
// Ports:
//   pclk, preset_n                     : clock, async active-low reset
//   req_valid/req_ready   [NUM_REQ]    : request handshake (ready one-hot)
//   req_addr  [NUM_REQ*ADDR_SIZE]      : packed per-requester address
//   req_write [NUM_REQ]                : 1 = write
//   req_wdata [NUM_REQ*DATA_SIZE]      : packed per-requester write data
//   rsp_valid [NUM_REQ], rsp_rdata     : completion pulse and read data
//   paddr, pwrite, pwdata, psel,
//   penable                            : APB master outputs (registered)
//   pready, prdata                     : APB slave response
// -----------------------------------------------------------------------------
module amba3_apb_arbiter
  import pkg_amba3::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int ADDR_SIZE = 32,
  parameter  int DATA_SIZE = 32,
  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_SIZE-1:0]           rsp_rdata,
  output logic [ADDR_SIZE-1:0]           paddr,
  output logic                           pwrite,
  output logic [DATA_SIZE-1:0]           pwdata,
  output logic                           psel,
  output logic                           penable,
  input  logic                           pready,
  input  logic [DATA_SIZE-1:0]           prdata
);

  amba3_apb_arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     pick_start;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     owner_q;
  logic                 accept;

  logic [ADDR_SIZE-1:0] addr_arr  [NUM_REQ];
  logic [DATA_SIZE-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_arr[g] = req_wdata[g*DATA_SIZE +: DATA_SIZE];
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef AMBA3_APB_ARBITER_RR_EN
  logic [PTR_W-1:0] rr_ptr_q;

  // Pointer holds the last granted index; resetting to NUM_REQ-1 makes the
  // first search after reset start at requester 0.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
    end else if (accept) begin
      rr_ptr_q <= win_idx;
    end
  end

  assign pick_start = (rr_ptr_q == PTR_W'(NUM_REQ - 1)) ? '0
                                                        : rr_ptr_q + PTR_W'(1);
`else
  assign pick_start = '0;
`endif

  amba3_apb_arb_pick #(
    .NUM_REQ   (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .pointer   (pick_start),
    .grant     (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values and simulation order between processes cannot matter.
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs
  // req_ready is a live view of the winner while IDLE, so a requester that
  // drops req_valid before the edge is simply not accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (arb_is_idle(state_q)) begin
      req_ready = grant;
      accept    = |grant;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered APB and response outputs
  // The APB payload registers double as the transfer latch: they are loaded
  // at accept, untouched through SETUP/ACCESS, and cleared at completion so
  // the bus reads zero whenever psel is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      owner_q   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= addr_arr[win_idx];
            pwrite  <= req_write[win_idx];
            pwdata  <= wdata_arr[win_idx];
            owner_q <= win_idx;
          end
        end
        SETUP: begin
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            psel               <= 1'b0;
            penable            <= 1'b0;
            pwrite             <= 1'b0;
            paddr              <= '0;
            pwdata             <= '0;
            rsp_valid[owner_q] <= 1'b1;
            rsp_rdata          <= pwrite ? '0 : prdata;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule : amba3_apb_arbiter
